// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller around an external dual-port memory.
// Push side writes straight into the memory. Reads are issued under a
// 2-credit rule. Returned words land in a 2-entry output buffer that
// drives the pop stream. A small checker flags mem_valid strobes that do
// not match the reads this block has issued.
module sync_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_valid,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH+1:0] level,
    output logic                  err_unexp,
    output logic                  err_miss,
    input  logic                  clr_err
);

    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(RAM_DEPTH);
    localparam logic [ADDR_WIDTH:0] PTR_ONE   = (ADDR_WIDTH+1)'(1);

    // Pointers carry one extra bit so that full and empty memory differ.
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [ADDR_WIDTH:0]   mem_count;
    logic                  inflight;
    logic [1:0]            ob_cnt;
    logic [DATA_WIDTH-1:0] ob_head;
    logic [DATA_WIDTH-1:0] ob_tail;
    logic                  pop;
    logic                  capture;
    logic [2:0]            credit_used;

    // Combinational control: flags, write/read issue, pop and capture strobes.
    // NOTE: every signal in this block is assigned on every pass, so no latch can be inferred.
    always_comb begin
        mem_count   = wr_ptr - rd_ptr;
        full        = (mem_count == DEPTH_CNT);
        in_ready    = !full;
        mem_wr_en   = in_valid & !full;
        mem_waddr   = wr_ptr[ADDR_WIDTH-1:0];
        mem_wdata   = in_data;
        out_valid   = (ob_cnt != 2'd0);
        out_data    = ob_head;
        pop         = out_valid & out_ready;
        // A strobe with no read outstanding is only an error, never data.
        capture     = mem_valid & inflight;
        // Words already owed to the buffer, less the one leaving this cycle.
        credit_used = {1'b0, ob_cnt} + {2'b00, inflight} - {2'b00, pop};
        mem_rd_en   = (mem_count != '0) && (credit_used < 3'd2);
        mem_raddr   = rd_ptr[ADDR_WIDTH-1:0];
        level       = {1'b0, mem_count}
                    + {{(ADDR_WIDTH+1){1'b0}}, inflight}
                    + {{ADDR_WIDTH{1'b0}}, ob_cnt};
        empty       = (level == '0);
    end

    // Pointer advance and read-in-flight tracking.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            inflight <= 1'b0;
        end else begin
            if (mem_wr_en) wr_ptr <= wr_ptr + PTR_ONE;
            if (mem_rd_en) rd_ptr <= rd_ptr + PTR_ONE;
            // Memory latency is fixed at one cycle, so a read is outstanding
            // exactly in the cycle after issue. A missing return is flagged
            // and the word is dropped rather than holding the credit forever.
            inflight <= mem_rd_en;
        end
    end

    // Two-entry in-order output buffer: capture into the tail, pop from the head.
    // NOTE: these few buffer registers are reset so out_data reads 0 after reset;
    // the bulk storage lives in the external memory, which is never reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ob_cnt  <= 2'd0;
            ob_head <= '0;
            ob_tail <= '0;
        end else begin
            case ({capture, pop})
                2'b10: begin
                    if (ob_cnt == 2'd0) ob_head <= mem_rdata;
                    else                ob_tail <= mem_rdata;
                    ob_cnt <= ob_cnt + 2'd1;
                end
                2'b01: begin
                    ob_head <= ob_tail;
                    ob_cnt  <= ob_cnt - 2'd1;
                end
                2'b11: begin
                    if (ob_cnt == 2'd2) begin
                        ob_head <= ob_tail;
                        ob_tail <= mem_rdata;
                    end else begin
                        ob_head <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    // Sticky protocol checker; a new error in the clearing cycle wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_unexp <= 1'b0;
            err_miss  <= 1'b0;
        end else begin
            err_unexp <= (mem_valid & ~inflight) | (err_unexp & ~clr_err);
            err_miss  <= (inflight & ~mem_valid) | (err_miss & ~clr_err);
        end
    end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Self-checking bench for sync_fifo_ctrl: a memory model with fault
// injection, a queue-based reference model checked every cycle, and
// directed plus randomised phases.
module tb_sync_fifo_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          mem_wr_en;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic          mem_rd_en;
    logic [AW-1:0] mem_raddr;
    logic [DW-1:0] mem_rdata;
    logic          mem_valid;
    logic          full;
    logic          empty;
    logic [AW+1:0] level;
    logic          err_unexp;
    logic          err_miss;
    logic          clr_err;

    logic          force_valid;
    logic          mask_valid;
    logic          mem_valid_q;
    logic [DW-1:0] ram [DEPTH];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int max_level = 0;
    int pops     = 0;
    bit chk_en   = 1'b1;

    logic [DW-1:0] q[$];
    int            tq[$];

    sync_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .mem_wr_en(mem_wr_en), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_rd_en(mem_rd_en), .mem_raddr(mem_raddr),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid),
        .full(full), .empty(empty), .level(level),
        .err_unexp(err_unexp), .err_miss(err_miss), .clr_err(clr_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog expired");
    end

    // Memory model: registered read, valid one cycle after rd_en, with injection.
    always @(posedge clk) begin
        if (mem_wr_en) ram[mem_waddr] <= mem_wdata;
        if (mem_rd_en) mem_rdata <= ram[mem_raddr];
        mem_valid_q <= mem_rd_en;
    end
    assign mem_valid = (mem_valid_q & ~mask_valid) | force_valid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a queue of accepted words with their accept cycle.
    // A word is visible exactly from 3 cycles after acceptance onwards, in order.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            tq.delete();
        end else begin
            if (chk_en) begin
                logic exp_valid;
                exp_valid = (q.size() != 0) && (cyc - tq[0] >= 3);
                check("out_valid", out_valid, exp_valid);
                if (exp_valid) check("out_data", out_data, q[0]);
                check("level", level, q.size());
                check("empty", empty, q.size() == 0);
                check("in_ready_vs_full", in_ready, !full);
                check("wr_en", mem_wr_en, in_valid & in_ready);
                if (q.size() < DEPTH)      check("in_ready_not_full", in_ready, 1);
                if (q.size() >= DEPTH + 2) check("in_ready_full", in_ready, 0);
                if (full)                  check("push_when_full", mem_wr_en, 0);
                check("no_errors", {err_unexp, err_miss}, 0);
                if (int'(level) > max_level) max_level = int'(level);
            end
            if (out_valid && out_ready && q.size() != 0) begin
                void'(q.pop_front());
                void'(tq.pop_front());
                pops++;
            end
            if (in_valid && in_ready) begin
                q.push_back(in_data);
                tq.push_back(cyc);
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        clr_err = 1'b0; force_valid = 1'b0; mask_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        while (!empty && n < 600) begin
            step();
            n++;
        end
        check(name, empty, 1);
    endtask

    task automatic fill(output int accepted);
        int n;
        n = 0;
        in_valid = 1'b1;
        out_ready = 1'b0;
        while (in_ready && n < 400) begin
            in_data = DW'($urandom);
            step();
            n++;
        end
        accepted = n;
    endtask

    initial begin
        int acc;
        int pops0;
        logic [DW-1:0] exp3 [3];
        exp3[0] = 8'h11; exp3[1] = 8'h22; exp3[2] = 8'h33;

        // Reset values
        do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_full", full, 0);
        check("rst_empty", empty, 1);
        check("rst_level", level, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_errs", {err_unexp, err_miss}, 0);
        check("rst_mem_en", {mem_wr_en, mem_rd_en}, 0);
        do_reset();

        // Three pushes, out_ready high: first word visible in cycle 3
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data = exp3[i];
            step();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t1_out_valid", out_valid, 1);
            check("t1_out_data", out_data, exp3[i]);
            step();
        end
        check("t1_empty_after", empty, 1);
        check("t1_out_valid_after", out_valid, 0);

        // Continuous stream 0..511 at full throughput, pointer wrap
        max_level = 0;
        pops0 = pops;
        out_ready = 1'b1;
        for (int i = 0; i < 512; i++) begin
            in_valid = 1'b1;
            in_data = DW'(i);
            step();
        end
        drain("t2_drain");
        check("t2_max_level_le3", max_level <= 3, 1);
        check("t2_pop_count", pops - pops0, 512);

        // Fill to capacity, extra push refused, then drain in order
        fill(acc);
        check("t3_accepted", acc, DEPTH + 2);
        repeat (3) step();
        check("t3_full", full, 1);
        check("t3_level", level, DEPTH + 2);
        check("t3_in_ready", in_ready, 0);
        drain("t3_drain");

        // Full with in_valid high and out_ready toggling
        fill(acc);
        for (int i = 0; i < 300; i++) begin
            in_valid = 1'b1;
            in_data = DW'($urandom);
            out_ready = $urandom_range(0, 1) == 1;
            step();
        end
        drain("t4_drain");

        // Random traffic, then a slow consumer to reach full repeatedly
        for (int i = 0; i < 2300; i++) begin
            in_valid = $urandom_range(0, 9) < 7;
            in_data = DW'($urandom);
            out_ready = (i < 1500) ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 9) < 2);
            step();
        end
        drain("t5_drain");

        // Checker: unexpected strobe with nothing in flight
        chk_en = 1'b0;
        force_valid = 1'b1;
        step();
        force_valid = 1'b0;
        check("err_unexp_set", err_unexp, 1);
        check("unexp_no_capture", out_valid, 0);
        check("unexp_level", level, 0);
        repeat (3) step();
        check("err_unexp_held", err_unexp, 1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check("err_unexp_clr", err_unexp, 0);
        force_valid = 1'b1;
        clr_err = 1'b1;
        step();
        force_valid = 1'b0;
        clr_err = 1'b0;
        check("err_set_wins", err_unexp, 1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;

        // Checker: masked return of an issued read
        mask_valid = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h5A;
        step();
        in_valid = 1'b0;
        step();
        step();
        check("err_miss_set", err_miss, 1);
        check("err_miss_no_unexp", err_unexp, 0);
        mask_valid = 1'b0;
        step();
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check("err_miss_clr", err_miss, 0);
        do_reset();
        chk_en = 1'b1;

        // Reset mid-stream with five entries held
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data = DW'($urandom);
            step();
        end
        in_valid = 1'b0;
        repeat (4) step();
        check("t6_level5", level, 5);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_empty", empty, 1);
        check("t6_level0", level, 0);
        check("t6_out_valid", out_valid, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 8'hA5;
        step();
        in_valid = 1'b0;
        check("t6_lat_c1", out_valid, 0);
        step();
        check("t6_lat_c2", out_valid, 0);
        step();
        check("t6_lat_c3", out_valid, 1);
        check("t6_data", out_data, 8'hA5);
        check("t6_no_unexp", err_unexp, 0);
        step();
        check("t6_empty_after", empty, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
